arbiter_wrr: RTL and testbench
==============================

ARBITER_WRR -- requirements
Module: arbiter_wrr

Interface
REQ-001 Parameter NUM_PORTS, default 9: number of requesting ports, 1 or more.
REQ-002 Parameter WEIGHT_W, default 4: width of each per-port quota field.
REQ-003 Parameter SEL_WIDTH, default $clog2(NUM_PORTS), or 1 when NUM_PORTS is 1: width of select.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-low.
REQ-006 mode  input  1  arbitration mode: 0 = weighted round-robin, 1 = fixed priority (lowest index wins).
REQ-007 request  input  NUM_PORTS  one request bit per port; level-sensitive.
REQ-008 weight  input  NUM_PORTS*WEIGHT_W  per-port quota; port i uses bits [i*WEIGHT_W +: WEIGHT_W]; sampled when a grant is issued.
REQ-009 grant  output  NUM_PORTS  registered one-hot grant; all-zero when idle.
REQ-010 select  output  SEL_WIDTH  registered binary index of the granted port.
REQ-011 active  output  1  registered; high when any grant bit is set.

Function
REQ-012 The block SHALL hold a registered owner, a quota counter (WEIGHT_W bits) and a round-robin pointer (last granted index).
REQ-013 Quota: weight value W SHALL entitle the owner to W+1 consecutive grant cycles; W=0 gives 1 cycle.
REQ-014 Round-robin pick: first requesting port searched cyclically from pointer+1, wrapping NUM_PORTS-1 to 0.
REQ-015 Fixed-priority pick (mode=1): lowest-index requesting port.
REQ-016 IDLE (active=0), any request at an edge: winner's grant SHALL be set at that edge, with one-cycle latency from request to grant. The quota counter loads weight[winner], and the pointer updates to the winner.
REQ-017 IDLE, no request: outputs SHALL stay zero.
REQ-018 Owner drops request: at the next edge the block SHALL pick among the remaining requests, with the owner's bit masked, and grant the winner with no idle bubble. If no other port requests, the block SHALL return to IDLE (grant 0, active 0).
REQ-019 Owner requesting, counter nonzero: grant SHALL hold and the counter SHALL decrement.
REQ-020 Owner requesting, counter zero, another port requesting: re-arbitrate at the edge, with the owner's bit masked in mode 0 and the owner included in mode 1. The new or same winner's quota SHALL be reloaded.
REQ-021 Owner requesting, counter zero, no other request: grant SHALL hold, quota reloaded from the current weight, no bubble.
REQ-022 grant SHALL always be one-hot or zero; select SHALL equal the index of the grant bit, or 0 when idle; active SHALL equal the OR of grant.
REQ-023 A change on mode SHALL take effect only at the next arbitration decision and SHALL NOT pre-empt an unexpired quota.
REQ-024 Changes on weight SHALL NOT affect a running quota.
REQ-025 Request bits above NUM_PORTS do not exist; no arithmetic on the pointer or the counter SHALL overflow its width.

Reset
REQ-026 When rst goes low, grant, select, active and the counter SHALL clear to 0 immediately, with no clock edge required.
REQ-027 On reset the pointer SHALL be set to NUM_PORTS-1, so port 0 wins the first round-robin arbitration.
REQ-028 A reset asserted mid-grant SHALL abandon the quota. After release, the first grant SHALL follow REQ-016 from the reset state.
REQ-029 With rst low, no output SHALL change regardless of request or mode.

Verification
REQ-030 NUM_PORTS=4, WEIGHT_W=4, mode=0, weights all 2, request=0101 held from reset release:
- grant=0001 for 3 cycles, then 0100 for 3 cycles, then alternating.
- The first grant appears one edge after the request is sampled.
REQ-031 request=0010 only, weight=0: grant=0010 continuously, active never drops, select=1.
REQ-032 Port 0 owns with quota 5 and request=0011; drop bit 0 after 2 grant cycles: at the next edge grant=0010, with no cycle where active=0.
REQ-033 mode=1, request=1010, weights 1: grant=0010 indefinitely, re-granted every 2 cycles; port 3 is never granted.
REQ-034 Assert rst low asynchronously between edges while grant=0100: all outputs 0 before the next edge. After release with request=1111 and weights 0, grant sequence is 0001, 0010, 0100, 1000, 0001.
REQ-035 NUM_PORTS=9, all requesting, weights 0: select steps 0..8 and wraps to 0, one port per cycle. Deasserting a single bit skips exactly that port.

Source files
------------

// File: rtl/arbiter_wrr.sv
// rtl/arbiter_wrr.sv - weighted round-robin / fixed-priority request arbiter
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   mode     0 = weighted round-robin, 1 = fixed priority (lowest index wins)
//   request  one level-sensitive request bit per port
//   weight   per-port quota, port i at [i*WEIGHT_W +: WEIGHT_W]; value W buys W+1 cycles
//   grant    registered one-hot grant, all-zero when idle
//   select   registered binary index of the granted port, 0 when idle
//   active   registered, high whenever a grant bit is set
`timescale 1ns/1ps

module arbiter_wrr #(
    parameter int NUM_PORTS = 9,
    parameter int WEIGHT_W  = 4,
    parameter int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic [NUM_PORTS-1:0]          request,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [SEL_WIDTH-1:0]          select,
    output logic                          active
);

    // Last granted index; reset to the top port so port 0 wins the first
    // round-robin search.
    localparam logic [SEL_WIDTH-1:0] PTR_RESET = SEL_WIDTH'(NUM_PORTS - 1);

    // Remaining extra grant cycles for the current owner. The owner itself
    // is the select register: it is only meaningful while active is high.
    logic [WEIGHT_W-1:0]  count;
    logic [SEL_WIDTH-1:0] pointer;

    logic [NUM_PORTS-1:0] nxt_grant;
    logic [SEL_WIDTH-1:0] nxt_select;
    logic                 nxt_active;
    logic [WEIGHT_W-1:0]  nxt_count;
    logic [SEL_WIDTH-1:0] nxt_pointer;

    logic [NUM_PORTS-1:0] owner_bit;
    logic [NUM_PORTS-1:0] others;
    logic [NUM_PORTS-1:0] cand;
    logic                 cand_fixed;
    logic                 do_arb;
    logic [SEL_WIDTH-1:0] win;

    // First requesting port found cyclically starting at ptr+1. The index is
    // formed in int arithmetic and reduced modulo NUM_PORTS, so the pointer
    // never wraps through its own width.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [SEL_WIDTH-1:0] ptr
    );
        logic found;
        int   idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                found   = 1'b1;
                rr_pick = SEL_WIDTH'(idx);
            end
        end
    endfunction

    // Lowest-index requesting port.
    function automatic logic [SEL_WIDTH-1:0] fp_pick(
        input logic [NUM_PORTS-1:0] req
    );
        fp_pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                fp_pick = SEL_WIDTH'(i);
            end
        end
    endfunction

    // Masks relative to the current owner.
    always_comb begin
        owner_bit         = '0;
        owner_bit[select] = 1'b1;
        others            = request & ~owner_bit;
    end

    // Decide whether this edge is an arbitration decision and which request
    // set it searches. Mode is only looked at here, so a mode change never
    // cuts a running quota short.
    always_comb begin
        do_arb     = 1'b0;
        cand       = '0;
        cand_fixed = mode;
        if (!active) begin
            if (|request) begin
                do_arb = 1'b1;
                cand   = request;
            end
        end else if (!request[select]) begin
            // Owner released: hand over with no idle bubble if anyone waits.
            if (|others) begin
                do_arb = 1'b1;
                cand   = others;
            end
        end else if (count == '0) begin
            if (|others) begin
                // Quota spent with competition: round-robin excludes the
                // owner, fixed priority lets it compete on index.
                do_arb = 1'b1;
                cand   = mode ? request : others;
            end else begin
                // Sole requester keeps the grant with a fresh quota.
                do_arb = 1'b1;
                cand   = owner_bit;
            end
        end
    end

    always_comb begin
        win = cand_fixed ? fp_pick(cand) : rr_pick(cand, pointer);
    end

    // Next-state for the registered outputs, counter and pointer.
    always_comb begin
        nxt_grant   = grant;
        nxt_select  = select;
        nxt_active  = active;
        nxt_count   = count;
        nxt_pointer = pointer;
        if (do_arb) begin
            nxt_grant      = '0;
            nxt_grant[win] = 1'b1;
            nxt_select     = win;
            nxt_active     = 1'b1;
            // Weight is sampled only here; later changes wait for the next win.
            nxt_count      = weight[win*WEIGHT_W +: WEIGHT_W];
            nxt_pointer    = win;
        end else if (active && request[select] && (count != '0)) begin
            nxt_count = count - WEIGHT_W'(1);
        end else if (active) begin
            // Owner dropped and nobody else is asking.
            nxt_grant  = '0;
            nxt_select = '0;
            nxt_active = 1'b0;
            nxt_count  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant   <= '0;
            select  <= '0;
            active  <= 1'b0;
            count   <= '0;
            pointer <= PTR_RESET;
        end else begin
            grant   <= nxt_grant;
            select  <= nxt_select;
            active  <= nxt_active;
            count   <= nxt_count;
            pointer <= nxt_pointer;
        end
    end

endmodule

// File: tb/tb_arbiter_wrr.sv
// tb/tb_arbiter_wrr.sv - scoreboard bench for arbiter_wrr at 4 and 9 ports
`timescale 1ns/1ps

module tb_arbiter_wrr;

    logic        clk;
    logic        rst;
    logic        mode4;
    logic [3:0]  req4;
    logic [15:0] wt4;
    logic [3:0]  grant4;
    logic [1:0]  sel4;
    logic        act4;
    logic        mode9;
    logic [8:0]  req9;
    logic [35:0] wt9;
    logic [8:0]  grant9;
    logic [3:0]  sel9;
    logic        act9;

    int checks = 0;
    int errors = 0;

    logic [3:0] q4[$];
    logic [8:0] q9[$];

    arbiter_wrr #(.NUM_PORTS(4), .WEIGHT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode4), .request(req4), .weight(wt4),
        .grant(grant4), .select(sel4), .active(act4)
    );

    arbiter_wrr #(.NUM_PORTS(9), .WEIGHT_W(4)) dut9 (
        .clk(clk), .rst(rst), .mode(mode9), .request(req9), .weight(wt9),
        .grant(grant9), .select(sel9), .active(act9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int onehot_idx(input logic [8:0] g);
        onehot_idx = 0;
        for (int i = 0; i < 9; i++) begin
            if (g[i]) onehot_idx = i;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant4"}, 32'(grant4), 32'd0);
        check({tag, "_sel4"},   32'(sel4),   32'd0);
        check({tag, "_act4"},   32'(act4),   32'd0);
        check({tag, "_grant9"}, 32'(grant9), 32'd0);
        check({tag, "_sel9"},   32'(sel9),   32'd0);
        check({tag, "_act9"},   32'(act9),   32'd0);
    endtask

    // Inputs are already set for the coming edge; queue what both DUTs
    // must show after it, then move to the next falling edge.
    task automatic tick(input logic [3:0] e4, input logic [8:0] e9);
        q4.push_back(e4);
        q9.push_back(e9);
        @(negedge clk);
    endtask

    // Monitor: after each rising edge, compare the outputs with the oldest
    // queued expectation.
    initial begin
        logic [3:0] e4;
        logic [8:0] e9;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                check("grant4",  32'(grant4), 32'(e4));
                check("select4", 32'(sel4),   32'(onehot_idx({5'd0, e4})));
                check("active4", 32'(act4),   32'(|e4));
            end
            if (q9.size() > 0) begin
                e9 = q9.pop_front();
                check("grant9",  32'(grant9), 32'(e9));
                check("select9", 32'(sel9),   32'(onehot_idx(e9)));
                check("active9", 32'(act9),   32'(|e9));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        mode4 = 1'b0;
        mode9 = 1'b0;
        req4  = '0;
        req9  = '0;
        wt4   = '0;
        wt9   = '0;

        // Asynchronous reset between edges clears everything at once.
        #7 rst = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);

        // Held in reset: requests and mode changes do nothing.
        req4  = 4'hf;
        mode4 = 1'b1;
        req9  = '1;
        tick(4'b0000, 9'd0);
        mode4 = 1'b0;
        tick(4'b0000, 9'd0);

        // Weights 2, request 0101 from release: 3 cycles each, alternating.
        req9 = '0;
        req4 = 4'b0101;
        wt4  = 16'h2222;
        rst  = 1'b1;
        repeat (3) tick(4'b0001, 9'd0);
        repeat (3) tick(4'b0100, 9'd0);
        repeat (3) tick(4'b0001, 9'd0);
        tick(4'b0100, 9'd0);

        // Owner 2 drops with quota left; port 1 alone with weight 0 is held.
        req4 = 4'b0010;
        wt4  = 16'h0000;
        repeat (5) tick(4'b0010, 9'd0);

        // Port 0 owns with quota 5; drop it after two grant cycles.
        req4 = 4'b0001;
        wt4  = 16'h0005;
        tick(4'b0001, 9'd0);
        req4 = 4'b0011;
        tick(4'b0001, 9'd0);
        req4 = 4'b0010;
        tick(4'b0010, 9'd0);
        tick(4'b0010, 9'd0);

        // Fixed priority, request 1010: port 1 keeps winning, port 3 starves.
        mode4 = 1'b1;
        req4  = 4'b1010;
        wt4   = 16'h1111;
        repeat (6) tick(4'b0010, 9'd0);

        // Get grant 0100, then reset in the middle of the low phase.
        mode4 = 1'b0;
        req4  = 4'b0100;
        tick(4'b0100, 9'd0);
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        req4 = 4'hf;
        wt4  = 16'h0000;
        rst  = 1'b1;
        tick(4'b0001, 9'd0);
        tick(4'b0010, 9'd0);
        tick(4'b0100, 9'd0);
        tick(4'b1000, 9'd0);
        tick(4'b0001, 9'd0);

        // Nine ports all requesting, weight 0: one port per cycle, wrapping.
        req4 = 4'b0000;
        req9 = 9'h1ff;
        for (int k = 0; k < 9; k++) begin
            tick(4'b0000, 9'd1 << k);
        end
        tick(4'b0000, 9'd1);
        // Port 4 drops out and is skipped.
        req9 = 9'h1ef;
        tick(4'b0000, 9'b000000010);
        tick(4'b0000, 9'b000000100);
        tick(4'b0000, 9'b000001000);
        tick(4'b0000, 9'b000100000);
        tick(4'b0000, 9'b001000000);
        tick(4'b0000, 9'b010000000);
        tick(4'b0000, 9'b100000000);
        tick(4'b0000, 9'b000000001);
        tick(4'b0000, 9'b000000010);

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
